// File: rtl/fetch_sequencer_pkg.sv
// Shared types and constants for the instruction fetch sequencer.
package fetch_sequencer_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [XLEN-1:0] INSTR_NOP = 32'h0000_0013;
  localparam logic [XLEN-1:0] PC_STEP   = 32'd4;

  typedef enum logic [1:0] {
    FS_IDLE = 2'd0,
    FS_REQ  = 2'd1,
    FS_WAIT = 2'd2,
    FS_HOLD = 2'd3
  } fetch_state_e;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
  } fetch_payload_t;

endpackage

// File: rtl/fetch_sequencer.sv
// Single-outstanding instruction fetch sequencer with redirect/flush handling.
// Optional: FETCH_MISALIGN_CHECK_EN parks the fetcher on misaligned redirect targets.
module fetch_sequencer
  import fetch_sequencer_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC  = 32'h0000_0000,
  parameter logic [XLEN-1:0] NOP_INSTR = INSTR_NOP
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            run,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_instr,
  output logic [XLEN-1:0] out_pc,
  output logic            fetch_misaligned
);

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            drop_q, drop_d;
  logic            out_valid_q, out_valid_d;
  logic            req_q, req_d;
  fetch_payload_t  hold_q, hold_d;
  logic            fetch_blocked_c;

`ifdef FETCH_MISALIGN_CHECK_EN
  logic misaligned_q, misaligned_d;
  assign fetch_blocked_c = misaligned_q;
`else
  assign fetch_blocked_c = 1'b0;
`endif

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= FS_IDLE;
      pc_q         <= RESET_PC;
      drop_q       <= 1'b0;
      out_valid_q  <= 1'b0;
      req_q        <= 1'b0;
      hold_q.instr <= NOP_INSTR;
      hold_q.pc    <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      drop_q      <= drop_d;
      out_valid_q <= out_valid_d;
      req_q       <= req_d;
      hold_q      <= hold_d;
    end
  end

`ifdef FETCH_MISALIGN_CHECK_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) misaligned_q <= 1'b0;
    else     misaligned_q <= misaligned_d;
  end
`endif

  // Next-state logic; a redirect outranks every other event in the cycle
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    drop_d      = drop_q;
    out_valid_d = out_valid_q;
    hold_d      = hold_q;
`ifdef FETCH_MISALIGN_CHECK_EN
    misaligned_d = misaligned_q;
`endif
    if (!out_valid_q) hold_d.instr = NOP_INSTR;

    unique case (state_q)
      FS_IDLE: begin
        if (redirect_valid)               pc_d    = redirect_pc;
        else if (run && !fetch_blocked_c) state_d = FS_REQ;
      end
      FS_REQ: begin
        if (redirect_valid) begin
          pc_d = redirect_pc;
          if (imem_gnt) begin
            drop_d  = 1'b1;
            state_d = FS_WAIT;
          end
        end else if (imem_gnt) begin
          state_d = FS_WAIT;
        end
      end
      FS_WAIT: begin
        if (redirect_valid) begin
          pc_d = redirect_pc;
          if (imem_rvalid) begin
            drop_d  = 1'b0;
            state_d = FS_REQ;
          end else begin
            drop_d = 1'b1;
          end
        end else if (imem_rvalid) begin
          if (drop_q) begin
            drop_d  = 1'b0;
            state_d = run ? FS_REQ : FS_IDLE;
          end else begin
            hold_d.instr = imem_rdata;
            hold_d.pc    = pc_q;
            out_valid_d  = 1'b1;
            pc_d         = pc_q + PC_STEP;
            state_d      = FS_HOLD;
          end
        end
      end
      FS_HOLD: begin
        if (redirect_valid) begin
          pc_d        = redirect_pc;
          out_valid_d = 1'b0;
          state_d     = FS_REQ;
        end else if (out_valid_q && out_ready) begin
          out_valid_d = 1'b0;
          state_d     = run ? FS_REQ : FS_IDLE;
        end
      end
      default: state_d = FS_IDLE;
    endcase

`ifdef FETCH_MISALIGN_CHECK_EN
    // Misaligned target parks the fetcher; only an aligned redirect releases it
    if (redirect_valid && (redirect_pc[1:0] != 2'b00)) begin
      misaligned_d = 1'b1;
      state_d      = FS_IDLE;
      drop_d       = 1'b0;
      out_valid_d  = 1'b0;
    end else if (redirect_valid && misaligned_q) begin
      misaligned_d = 1'b0;
      state_d      = FS_REQ;
    end
`endif

    req_d = (state_d == FS_REQ);
  end

  assign imem_req  = req_q;
  assign imem_addr = pc_q;
  assign out_valid = out_valid_q & ~redirect_valid;
  assign out_instr = hold_q.instr;
  assign out_pc    = hold_q.pc;

`ifdef FETCH_MISALIGN_CHECK_EN
  assign fetch_misaligned = misaligned_q;
`else
  assign fetch_misaligned = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed self-checking bench for fetch_sequencer with a handshake scoreboard.
module tb_fetch_sequencer;
  import fetch_sequencer_pkg::*;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            run = 1'b0;
  logic            imem_req;
  logic [31:0]     imem_addr;
  logic            imem_gnt = 1'b0;
  logic            imem_rvalid = 1'b0;
  logic [31:0]     imem_rdata = '0;
  logic            redirect_valid = 1'b0;
  logic [31:0]     redirect_pc = '0;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic [31:0]     out_instr;
  logic [31:0]     out_pc;
  logic            fetch_misaligned;

  int checks = 0;
  int errors = 0;
  int cycle  = 0;
  fetch_payload_t sb[$];
  int hs_cyc[$];

  fetch_sequencer dut (
    .clk(clk), .rst(rst), .run(run),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_pc(out_pc),
    .fetch_misaligned(fetch_misaligned)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Handshake monitor: pops the scoreboard on every accepted instruction
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      hs_cyc.push_back(cycle);
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $error("FAIL unexpected_handshake observed pc=%h expected no transfer", out_pc);
      end else begin
        fetch_payload_t e;
        e = sb.pop_front();
        check("sb_instr", out_instr, e.instr);
        check("sb_pc", out_pc, e.pc);
      end
    end
  end

  // From REQ: grant, respond next cycle, end sampled in HOLD
  task automatic do_fetch(input logic [31:0] addr, input logic [31:0] data, input bit push);
    fetch_payload_t p;
    check("req_high", 32'(imem_req), 32'd1);
    check("req_addr", imem_addr, addr);
    imem_gnt = 1'b1;
    tick();
    imem_gnt = 1'b0;
    check("wait_no_req", 32'(imem_req), 32'd0);
    imem_rvalid = 1'b1;
    imem_rdata  = data;
    if (push) begin
      p.instr = data;
      p.pc    = addr;
      sb.push_back(p);
    end
    tick();
    imem_rvalid = 1'b0;
    check("hold_valid", 32'(out_valid), 32'd1);
    check("hold_instr", out_instr, data);
    check("hold_pc", out_pc, addr);
  endtask

  initial begin
    // 1: reset values, then back-to-back fetches
    tick();
    tick();
    check("rst_req", 32'(imem_req), 32'd0);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_instr", out_instr, 32'h0000_0013);
    check("rst_pc", out_pc, 32'h0);
    check("rst_mis", 32'(fetch_misaligned), 32'd0);
    run = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    tick();
    do_fetch(32'h0, 32'h0050_0093, 1'b1);
    tick();
    do_fetch(32'h4, 32'h0050_0093, 1'b1);
    tick();
    do_fetch(32'h8, 32'h0050_0093, 1'b1);
    tick();
    check("hs_count", 32'(hs_cyc.size()), 32'd3);
    if (hs_cyc.size() == 3) begin
      check("hs_gap0", 32'(hs_cyc[1] - hs_cyc[0]), 32'd3);
      check("hs_gap1", 32'(hs_cyc[2] - hs_cyc[1]), 32'd3);
    end

    // 2: decoder stall in HOLD
    out_ready = 1'b0;
    do_fetch(32'hC, 32'h0010_8113, 1'b1);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("stall_valid", 32'(out_valid), 32'd1);
      check("stall_instr", out_instr, 32'h0010_8113);
      check("stall_req", 32'(imem_req), 32'd0);
    end
    out_ready = 1'b1;
    tick();
    check("post_stall_req", 32'(imem_req), 32'd1);
    check("post_stall_addr", imem_addr, 32'h10);

    // 3: redirect while waiting drops the in-flight response
    imem_gnt = 1'b1;
    tick();
    imem_gnt = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc = 32'h100;
    tick();
    redirect_valid = 1'b0;
    imem_rvalid = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    tick();
    imem_rvalid = 1'b0;
    check("drop_valid", 32'(out_valid), 32'd0);
    check("drop_req", 32'(imem_req), 32'd1);
    check("drop_addr", imem_addr, 32'h100);
    do_fetch(32'h100, 32'h0020_8193, 1'b1);
    tick();

    // 4: redirect coincident with rvalid, then redirect in HOLD
    imem_gnt = 1'b1;
    tick();
    imem_gnt = 1'b0;
    imem_rvalid = 1'b1;
    imem_rdata = 32'h1111_1111;
    redirect_valid = 1'b1;
    redirect_pc = 32'h200;
    tick();
    imem_rvalid = 1'b0;
    redirect_valid = 1'b0;
    check("rv_redir_valid", 32'(out_valid), 32'd0);
    check("rv_redir_addr", imem_addr, 32'h200);
    do_fetch(32'h200, 32'h2222_2222, 1'b0);
    redirect_valid = 1'b1;
    redirect_pc = 32'h300;
    #1;
    check("hold_redir_valid", 32'(out_valid), 32'd0);
    tick();
    redirect_valid = 1'b0;
    check("hold_redir_req", 32'(imem_req), 32'd1);
    check("hold_redir_addr", imem_addr, 32'h300);
    check("hold_redir_vq", 32'(out_valid), 32'd0);

    // 5: reset during WAIT, stale response, run low parks in IDLE
    imem_gnt = 1'b1;
    tick();
    imem_gnt = 1'b0;
    rst = 1'b1;
    #1;
    check("mid_rst_req", 32'(imem_req), 32'd0);
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    check("mid_rst_instr", out_instr, 32'h0000_0013);
    check("mid_rst_pc", out_pc, 32'h0);
    check("mid_rst_addr", imem_addr, 32'h0);
    run = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    imem_rvalid = 1'b1;
    imem_rdata = 32'h3333_3333;
    tick();
    imem_rvalid = 1'b0;
    check("stale_valid", 32'(out_valid), 32'd0);
    check("stale_instr", out_instr, 32'h0000_0013);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("park_req", 32'(imem_req), 32'd0);
    end
    run = 1'b1;
    tick();
    check("resume_req", 32'(imem_req), 32'd1);
    check("resume_addr", imem_addr, 32'h0);

    // 6: misaligned redirect target
    redirect_valid = 1'b1;
    redirect_pc = 32'h102;
    tick();
    redirect_valid = 1'b0;
`ifdef FETCH_MISALIGN_CHECK_EN
    check("mis_flag", 32'(fetch_misaligned), 32'd1);
    check("mis_req", 32'(imem_req), 32'd0);
    for (int i = 0; i < 2; i++) begin
      tick();
      check("mis_park_req", 32'(imem_req), 32'd0);
    end
    redirect_valid = 1'b1;
    redirect_pc = 32'h104;
    tick();
    redirect_valid = 1'b0;
    check("mis_clear", 32'(fetch_misaligned), 32'd0);
    do_fetch(32'h104, 32'h4444_4444, 1'b1);
`else
    check("mis_tied", 32'(fetch_misaligned), 32'd0);
    do_fetch(32'h102, 32'h4444_4444, 1'b1);
`endif
    tick();
    check("sb_empty", 32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
